// File: rtl/delay_values_pkg.sv
// delay_values_pkg: shared defaults, register field offsets and FSM state for delay_values_apply
package delay_values_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DELAY_W = 10;
  localparam int DEF_STABLE_CYC = 2;
  localparam int DLY0_LSB = 0;
  localparam int DLY1_LSB = 16;
  typedef enum logic {IDLE, ARMED} state_t;
endpackage

// File: rtl/delay_ring.sv
// delay_ring: one input's ring-buffer delay line with d=0 bypass and a two-cycle output path
module delay_ring
  import delay_values_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DELAY_W = DEF_DELAY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DELAY_W-1:0] wr_ptr,
  input  logic [DELAY_W-1:0] d,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout
);
  logic [DATA_W-1:0] mem [2**DELAY_W];
  logic [DATA_W-1:0] ram_q, byp_q;
  logic byp_sel;
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
      ram_q <= mem[wr_ptr - d];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= '0;
      byp_sel <= 1'b1;
      dout <= '0;
    end else begin
      if (wr_en) begin
        byp_q <= din;
        byp_sel <= d == '0;
      end
      dout <= byp_sel ? byp_q : ram_q;
    end
  end
endmodule

// File: rtl/delay_values_apply.sv
// delay_values_apply: debounce delay register, arm on change, apply per-input sample delays at sync
module delay_values_apply
  import delay_values_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int STABLE_CYC = DEF_STABLE_CYC
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       delay_word,
  input  logic              sync_in,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout0,
  output logic [DATA_W-1:0] dout1,
  output logic              sync_out,
  output logic              pending,
  output logic              settling,
  output logic [15:0]       apply_count
);
  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  state_t state, state_n;
  logic [31:0] prev_word;
  logic [STAB_W-1:0] stab, stab_n;
  logic [DELAY_W-1:0] f0, f1, act0, act1, act0_n, act1_n, sh0, sh1, sh0_n, sh1_n;
  logic [DELAY_W-1:0] fill, fill_n, wr_ptr, mx;
  logic [15:0] cnt_n;
  logic eq, stable, req, apply, cap, v1, s1;
  always_comb begin
    f0 = delay_word[DLY0_LSB +: DELAY_W];
    f1 = delay_word[DLY1_LSB +: DELAY_W];
    eq = delay_word == prev_word;
    stab_n = !eq ? '0 : stab == STAB_W'(STABLE_CYC) ? stab : stab + 1'b1;
    stable = eq && stab >= STAB_W'(STABLE_CYC - 1);
    req = stable && (f0 != act0 || f1 != act1);
    apply = state == ARMED && sync_in;
    cap = state == IDLE ? req : stable && !sync_in;
    state_n = state == IDLE ? (req ? ARMED : IDLE) : (sync_in ? IDLE : ARMED);
    sh0_n = cap ? f0 : sh0;
    sh1_n = cap ? f1 : sh1;
    act0_n = apply ? sh0 : act0;
    act1_n = apply ? sh1 : act1;
    cnt_n = apply ? apply_count + 16'd1 : apply_count;
    fill_n = apply ? '0 : (din_valid && fill != '1) ? fill + 1'b1 : fill;
    mx = act0_n > act1_n ? act0_n : act1_n;
  end
  assign pending = state == ARMED;
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= IDLE;
      prev_word <= '0;
      stab <= '0;
      act0 <= '0;
      act1 <= '0;
      sh0 <= '0;
      sh1 <= '0;
      fill <= '0;
      wr_ptr <= '0;
      apply_count <= '0;
      settling <= 1'b1;
      v1 <= 1'b0;
      s1 <= 1'b0;
      dout_valid <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      state <= state_n;
      prev_word <= delay_word;
      stab <= stab_n;
      act0 <= act0_n;
      act1 <= act1_n;
      sh0 <= sh0_n;
      sh1 <= sh1_n;
      fill <= fill_n;
      wr_ptr <= din_valid ? wr_ptr + 1'b1 : wr_ptr;
      apply_count <= cnt_n;
      settling <= fill_n < mx;
      v1 <= din_valid;
      s1 <= sync_in;
      dout_valid <= v1;
      sync_out <= s1;
    end
  end
  delay_ring #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) u_ring0 (
    .clk(user_clk), .rst(user_rst), .wr_en(din_valid), .wr_ptr(wr_ptr), .d(act0), .din(din0), .dout(dout0)
  );
  delay_ring #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) u_ring1 (
    .clk(user_clk), .rst(user_rst), .wr_en(din_valid), .wr_ptr(wr_ptr), .d(act1), .din(din1), .dout(dout1)
  );
endmodule

// File: tb/tb_delay_values_apply.sv
// tb_delay_values_apply: directed self-checking bench for delay_values_apply
module tb_delay_values_apply;
  logic user_clk = 1'b0, user_rst = 1'b1, sync_in = 1'b0, din_valid = 1'b0;
  logic [31:0] delay_word = '0;
  logic [15:0] din0 = '0, din1 = '0;
  logic dout_valid, sync_out, pending, settling;
  logic [15:0] dout0, dout1, apply_count;
  int npass = 0, ntot = 0, n = 0, base = 0, ed0 = 0, ed1 = 0, n_far = 0, nv = 0;
  int q_idx[$], q_d0[$], q_d1[$];
  bit vh1, vh2, sh1, sh2;
  delay_values_apply dut (
    .user_clk(user_clk), .user_rst(user_rst), .delay_word(delay_word), .sync_in(sync_in),
    .din_valid(din_valid), .din0(din0), .din1(din1), .dout_valid(dout_valid), .dout0(dout0),
    .dout1(dout1), .sync_out(sync_out), .pending(pending), .settling(settling), .apply_count(apply_count)
  );
  always #5 user_clk = ~user_clk;
  function automatic logic [15:0] s0(int i);
    return 16'(i);
  endfunction
  function automatic logic [15:0] s1(int i);
    return 16'(1000 + i);
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic cyc(bit v, bit s);
    int idx, a, b;
    din_valid = v;
    sync_in = s;
    din0 = s0(n);
    din1 = s1(n);
    if (v) begin
      q_idx.push_back(n);
      q_d0.push_back(ed0);
      q_d1.push_back(ed1);
      n++;
    end
    @(posedge user_clk);
    #1;
    vh2 = vh1;
    vh1 = v;
    sh2 = sh1;
    sh1 = s;
    chk("dout_valid", dout_valid, vh2);
    chk("sync_out", sync_out, sh2);
    if (dout_valid && q_idx.size() > 0) begin
      idx = q_idx.pop_front();
      a = q_d0.pop_front();
      b = q_d1.pop_front();
      if (idx - a >= base) begin
        chk("dout0", dout0, s0(idx - a));
        if (a == 1023) n_far++;
      end
      if (idx - b >= base) chk("dout1", dout1, s1(idx - b));
    end
  endtask
  task automatic do_reset();
    user_rst = 1'b1;
    din_valid = 1'b0;
    sync_in = 1'b0;
    delay_word = '0;
    repeat (2) @(posedge user_clk);
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout0", dout0, 0);
    chk("rst_dout1", dout1, 0);
    chk("rst_sync_out", sync_out, 0);
    chk("rst_pending", pending, 0);
    chk("rst_settling", settling, 1);
    chk("rst_apply_count", apply_count, 0);
    q_idx.delete();
    q_d0.delete();
    q_d1.delete();
    vh1 = 0; vh2 = 0; sh1 = 0; sh2 = 0;
    base = n;
    ed0 = 0;
    ed1 = 0;
    user_rst = 1'b0;
  endtask
  initial begin
    do_reset();
    cyc(1, 0);
    chk("settle_after_rst", settling, 0);
    repeat (20) begin
      cyc(1, 0);
      chk("t1_settling", settling, 0);
      chk("t1_pending", pending, 0);
    end
    for (int i = 0; i < 12; i++) begin
      delay_word = (i % 2) ? 32'h1 : 32'h2;
      cyc(1, 0);
      chk("tog_pending", pending, 0);
    end
    delay_word = '0;
    repeat (3) cyc(1, 0);
    cyc(1, 1);
    chk("tog_count", apply_count, 0);
    chk("tog_pending_sync", pending, 0);
    repeat (3) cyc(1, 0);
    delay_word = 32'h0005_0003;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0);
      chk("arm_pending", pending, i >= 2);
    end
    cyc(1, 1);
    ed0 = 3;
    ed1 = 5;
    chk("apply1_pending", pending, 0);
    chk("apply1_count", apply_count, 1);
    chk("apply1_settling", settling, 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0);
      chk("settle5", settling, i < 5);
    end
    repeat (10) cyc(1, 0);
    delay_word = 32'h4;
    repeat (5) cyc(1, 0);
    chk("two_pending_a", pending, 1);
    delay_word = 32'h7;
    repeat (5) cyc(1, 0);
    chk("two_pending_b", pending, 1);
    cyc(1, 1);
    ed0 = 7;
    ed1 = 0;
    chk("apply2_count", apply_count, 2);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0);
      chk("settle7", settling, i < 7);
    end
    delay_word = 32'hFC00_FC07;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0);
      chk("resv_pending", pending, 0);
    end
    delay_word = 32'h0000_03FF;
    repeat (5) cyc(1, 0);
    chk("far_pending", pending, 1);
    cyc(1, 1);
    ed0 = 1023;
    ed1 = 0;
    chk("apply3_count", apply_count, 3);
    for (int i = 0; i < 2300; i++) begin
      cyc(i % 2 == 0, 0);
      if (i % 2 == 0) begin
        nv++;
        if (nv == 1022) chk("settle1023_pre", settling, 1);
        if (nv == 1023) chk("settle1023_post", settling, 0);
      end
    end
    chk("far_checks_seen", n_far > 0, 1);
    delay_word = 32'h9;
    repeat (5) cyc(1, 0);
    chk("pre_rst_pending", pending, 1);
    do_reset();
    cyc(1, 0);
    chk("post_rst_settling", settling, 0);
    cyc(1, 1);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_count", apply_count, 0);
    repeat (6) begin
      cyc(1, 0);
      chk("post_rst_idle", pending, 0);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/delay_values_apply.md
Name: delay_values_apply

Overview:
- Downstream consumer of the 32-bit delay_values software register, which presents user_data_out in the user_clk domain.
- Debounces the register word and holds each change pending until the next sync pulse.
- On that pulse, applies two per-input coarse integer-sample delays to the two-input ADC sample stream.
- Sits between the ADC capture stage and the PFB/FFT front end.

Parameters:
DATA_W, 16, width of one input's sample word per clock
DELAY_W, 10, delay field width; max delay is 2^DELAY_W-1 samples
STABLE_CYC, 2, cycles delay_word must hold unchanged before it counts as a new request

Ports:
user_clk  in  1  sole clock; all logic in this domain
user_rst  in  1  synchronous, active-high reset
delay_word  in  32  delay register value; [DELAY_W-1:0] = delay input 0, [16+DELAY_W-1:16] = delay input 1; other bits ignored
sync_in  in  1  one-cycle spectrum-boundary pulse
din_valid  in  1  sample qualifier
din0  in  DATA_W  input 0 sample
din1  in  DATA_W  input 1 sample
dout_valid  out  1  output qualifier
dout0  out  DATA_W  delayed input 0
dout1  out  DATA_W  delayed input 1
sync_out  out  1  sync_in aligned to the output pipeline
pending  out  1  new delays captured, waiting for sync
settling  out  1  buffers not yet refilled after an apply
apply_count  out  16  number of applies since reset; wraps

Behaviour:
- Reset (user_rst high at a rising edge):
  - Outputs: dout_valid=0, dout0/1=0, sync_out=0, pending=0, settling=1, apply_count=0.
  - Internal state: active delays=0, write pointer=0, fill counter=0, state=IDLE.
  - RAM contents are not cleared.
  - Reset mid-stream discards any pending request.
- Debounce:
  - A stability counter counts cycles in which delay_word equals its previous value.
  - Once it reaches STABLE_CYC, the word is "stable".
  - A stable word whose delay fields differ from the active delays raises a request.
  - Reserved-bit-only changes never raise a request.
- FSM, two states:
  - IDLE: on a request, latch the new fields into a shadow register, set pending=1, go to ARMED.
  - ARMED:
    - A further stable change overwrites the shadow; stay ARMED.
    - On sync_in=1: copy shadow to active, pending=0, apply_count+=1, clear fill counter, settling=1, go to IDLE.
  - sync_in and a new stable word in the same cycle while IDLE: capture the word only; it applies at the next sync.
  - Delay fields equal to the active delays never arm.
- Delay line, one ring buffer per input:
  - Depth 2^DELAY_W, DATA_W wide, simple dual-port RAM.
  - Write at wr_ptr on din_valid; wr_ptr increments modulo 2^DELAY_W.
  - Read address = wr_ptr - d (modulo arithmetic).
  - Delay d=0 returns the sample written on the same valid, via a write-first bypass.
- Output path:
  - Fixed latency of 2 cycles from din_valid to dout_valid, independent of d.
  - sync_out is delayed by the same 2 cycles.
  - Output sample k equals input sample k-d.
  - din_valid gaps stall pointers; the RAM is untouched when invalid.
- Settling:
  - After each apply, the fill counter counts valid samples, saturating at 2^DELAY_W-1.
  - settling deasserts once the counter reaches max(d0,d1).
  - While settling, output data may be stale but must still be produced.
  - After reset, settling clears once max(d0,d1) valid samples have been written; with active delays 0 this is immediate (settling=0 on the first cycle after reset releases).
- The change is effective from the first sample written on the cycle after the sync_in apply cycle.
- A pointer jump of up to 2^DELAY_W-1 must not glitch valid timing.
- apply_count wraps 0xFFFF to 0x0000.

Decomposition:
- Package delay_values_pkg:
  - DELAY_W, DATA_W defaults and STABLE_CYC.
  - Field offsets (DLY0_LSB=0, DLY1_LSB=16).
  - FSM state typedef {IDLE, ARMED}.
- Sub-module delay_ring:
  - One per input: RAM, write pointer, read-address subtract, d=0 bypass, 2-stage output register.
  - Instantiated twice with a shared write pointer.
- Top level holds the debounce, FSM, fill counter and status outputs.

Test Plan:
- Reset, delay_word=0, ramp din0=n, din1=1000+n every cycle -> dout0=n, dout1=1000+n two cycles later; settling=0 and pending=0.
- delay_word=0x0005_0003 held 2 cycles, sync_in 10 cycles later:
  - pending=1 until sync.
  - After apply: dout0=n-3, dout1=n-5; apply_count=1.
  - settling drops after 5 valid samples.
- delay_word toggles every cycle (0x1/0x2), never stable 2 cycles -> pending stays 0; sync_in causes no change; apply_count=0.
- Two stable changes (0x0000_0004, then 0x0000_0007) before one sync -> single apply with d0=7; apply_count increments by 1.
- din_valid toggling 1-0-1 with d0=1023 -> dout0 equals the input 1023 valid samples earlier; pointer wrap at 1023->0 is seamless.
- user_rst asserted while ARMED -> pending=0, active delays 0, apply_count=0; the following sync_in has no effect.
